mem_access_ctrl: RTL



---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/rise_pulse.sv | 23 ++
 rtl/mem_access_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: request mode codes, FSM state type and default widths
// shared by mem_access_ctrl and its sub-blocks.
// Optional feature macro: WRITE_VERIFY_EN adds the verify-read states.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CLR_REQ
`ifdef WRITE_VERIFY_EN
    ,
    ST_VFY_REQ,
    ST_VFY_WAIT
`endif
  } state_e;

  // Bits needed for a counter that must reach max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// rise_pulse: rising-edge detector. The previous-value register is updated
// every cycle, so an edge is reported exactly once regardless of who listens.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Track last cycle's level of the monitored signal.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: executes one memory transaction (write, read or zero-fill
// clear) per io_done rising edge on an Avalon-MM style master port.
// Optional feature macro: WRITE_VERIFY_EN (read-back compare after each
// single write, result reported on verify_err).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CLEAR_WORDS = 1024,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_done,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              mem_done,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              rd_timeout,
  output logic              verify_err,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  output logic [1:0]        av_byteenable,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid
);

  localparam int              TO_W     = cnt_width(RD_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(RD_TIMEOUT);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic [TO_W-1:0]     to_cnt_q,     to_cnt_d;
  logic                mem_done_q,   mem_done_d;
  logic [DATA_W-1:0]   read_data_q,  read_data_d;
  logic                read_valid_q, read_valid_d;
  logic                rd_timeout_q, rd_timeout_d;
  logic                verify_err_q, verify_err_d;
  logic                req_rise;

  rise_pulse u_rise (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (io_done),
    .rise_o (req_rise)
  );

  // Next-state and datapath decisions; every target defaults to hold.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    to_cnt_d     = to_cnt_q;
    mem_done_d   = mem_done_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    rd_timeout_d = rd_timeout_q;
    verify_err_d = verify_err_q;

    case (state_q)
      ST_IDLE: begin
        // Edges while busy never reach here, so they are dropped, not queued.
        if (req_rise && (mode != MODE_IDLE)) begin
          mem_done_d   = 1'b0;
          rd_timeout_d = 1'b0;
          addr_d       = mem_addr;
          wdata_d      = io_data;
          case (mode)
            MODE_CLEAR: begin
              state_d = ST_CLR_REQ;
              addr_d  = '0;
              wdata_d = '0;
            end
            MODE_READ: state_d = ST_RD_REQ;
            default:   state_d = ST_WR_REQ;
          endcase
        end
      end

      ST_WR_REQ: begin
        if (!av_waitrequest) begin
`ifdef WRITE_VERIFY_EN
          state_d = ST_VFY_REQ;
`else
          state_d    = ST_IDLE;
          mem_done_d = 1'b1;
`endif
        end
      end

      ST_RD_REQ: begin
        if (!av_waitrequest) begin
          state_d  = ST_RD_WAIT;
          to_cnt_d = '0;
        end
      end

      ST_RD_WAIT: begin
        // Data arriving on the last counted cycle still wins over timeout.
        if (av_readdatavalid) begin
          read_data_d  = av_readdata;
          read_valid_d = 1'b1;
          mem_done_d   = 1'b1;
          state_d      = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          rd_timeout_d = 1'b1;
          mem_done_d   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_CLR_REQ: begin
        // Address advances only on acceptance and stops at the last word.
        if (!av_waitrequest) begin
          if (addr_q == CLR_LAST) begin
            state_d    = ST_IDLE;
            mem_done_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

`ifdef WRITE_VERIFY_EN
      ST_VFY_REQ: begin
        if (!av_waitrequest) begin
          state_d  = ST_VFY_WAIT;
          to_cnt_d = '0;
        end
      end

      ST_VFY_WAIT: begin
        // Verify reads never touch read_data/read_valid.
        if (av_readdatavalid) begin
          if (av_readdata != wdata_q) begin
            verify_err_d = 1'b1;
          end
          mem_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          verify_err_d = 1'b1;
          mem_done_d   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // State register and all registered outputs; rst aborts any bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      to_cnt_q     <= '0;
      mem_done_q   <= 1'b1;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      rd_timeout_q <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      to_cnt_q     <= to_cnt_d;
      mem_done_q   <= mem_done_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      rd_timeout_q <= rd_timeout_d;
      verify_err_q <= verify_err_d;
    end
  end

  // Bus strobes decode straight from the registered state, so they are
  // glitch-free and mutually exclusive by construction.
  assign av_write = (state_q == ST_WR_REQ) || (state_q == ST_CLR_REQ);
`ifdef WRITE_VERIFY_EN
  assign av_read    = (state_q == ST_RD_REQ) || (state_q == ST_VFY_REQ);
  assign verify_err = verify_err_q;
`else
  assign av_read    = (state_q == ST_RD_REQ);
  assign verify_err = 1'b0;
`endif

  assign av_address    = addr_q;
  assign av_writedata  = wdata_q;
  assign av_byteenable = 2'b11;
  assign mem_done      = mem_done_q;
  assign read_data     = read_data_q;
  assign read_valid    = read_valid_q;
  assign rd_timeout    = rd_timeout_q;

endmodule
